// File: rtl/eth_tx_sequencer_pkg.sv
// Shared types, frame-layout constants and CRC-32 helpers for the Ethernet TX sequencer.
package eth_pkg;

  typedef enum logic [2:0] {
    IDLE,
    PREAMBLE,
    HEADER,
    PAYLOAD,
    PAD,
    FCS,
    IFG
  } state_t;

  localparam int          PREAMBLE_DIBITS = 32;
  localparam int          HEADER_DIBITS   = 56;
  localparam int          FCS_DIBITS      = 16;
  localparam logic [31:0] CRC_POLY        = 32'hEDB8_8320;
  localparam logic [31:0] CRC_INIT        = 32'hFFFF_FFFF;

  // One bit of the reflected CRC-32 recurrence.
  function automatic logic [31:0] crc_step(input logic [31:0] c, input logic b);
    crc_step = (c[0] ^ b) ? ((c >> 1) ^ CRC_POLY) : (c >> 1);
  endfunction

  // Reorders a big-endian header so the first byte on the wire sits in bits [7:0].
  function automatic logic [111:0] wire_order(input logic [111:0] h);
    wire_order = '0;
    for (int i = 0; i < 14; i++) begin
      wire_order[8*i +: 8] = h[8*(13-i) +: 8];
    end
  endfunction

endpackage

// File: rtl/eth_tx_sequencer_crc32_dibit.sv
// Reflected CRC-32 accumulator, two bits per clock (din[0] first); result valid one cycle after en.
module crc32_dibit
  import eth_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        en,
  input  logic [1:0]  din,
  output logic [31:0] crc
);

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      crc <= CRC_INIT;
    end else if (en) begin
      crc <= crc_step(crc_step(crc, din[0]), din[1]);
    end
  end

endmodule

// File: rtl/eth_tx_sequencer.sv
// Ethernet TX frame sequencer: preamble/SFD, header, payload, pad, FCS, IFG at one dibit per clk.
// Registered outputs, payload dibit appears one cycle after acceptance; pay_ready only in PAYLOAD.
module eth_tx_sequencer
  import eth_pkg::*;
#(
  parameter logic [47:0] DEST_MAC          = 48'h692C_0830_75FD,
  parameter logic [47:0] SRC_MAC           = 48'hFFFF_FFFF_FFFF,
  parameter logic [15:0] ETHERTYPE         = 16'h0800,
  parameter int          MIN_PAYLOAD_BYTES = 46,
  parameter int          MAX_PAYLOAD_BYTES = 1500,
  parameter int          IFG_BYTES         = 12
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pay_axiiv,
  input  logic [1:0] pay_axiid,
  input  logic       pay_axiil,
  output logic       pay_ready,
  output logic       axiov,
  output logic [1:0] axiod,
  output logic       busy,
  output logic       frame_done,
  output logic       underrun
);

  localparam logic [12:0] MIN_DIBITS = 13'(4 * MIN_PAYLOAD_BYTES);
  localparam logic [12:0] MAX_DIBITS = 13'(4 * MAX_PAYLOAD_BYTES);
  localparam logic [5:0]  PRE_LAST   = 6'(PREAMBLE_DIBITS - 1);
  localparam logic [5:0]  HDR_LAST   = 6'(HEADER_DIBITS - 1);
  localparam logic [5:0]  FCS_LAST   = 6'(FCS_DIBITS - 1);
  // The registered output adds one idle cycle, so the state itself lasts one cycle less.
  localparam logic [5:0]  IFG_LAST   = 6'(4 * IFG_BYTES - 2);

  state_t        state, state_nxt;
  logic [5:0]    phase;
  logic [12:0]   pay_cnt;
  logic [12:0]   pay_cnt_inc;
  logic [111:0]  hdr_sr;
  logic [31:0]   crc;
  logic [31:0]   crc_inv;
  logic          crc_clear, crc_en;
  logic [1:0]    crc_din;
  logic          nxt_v, nxt_ur;
  logic [1:0]    nxt_d;
  logic          frame_full;
  logic          fcs_end;

  assign pay_cnt_inc = pay_cnt + 13'd1;
  assign frame_full  = (pay_cnt_inc[1:0] == 2'b00) && (pay_cnt_inc >= MIN_DIBITS);
  assign crc_inv     = ~crc;
  assign busy        = (state != IDLE);

  crc32_dibit u_crc (
    .clk   (clk),
    .rst   (rst),
    .clear (crc_clear),
    .en    (crc_en),
    .din   (crc_din),
    .crc   (crc)
  );

  always_comb begin
    state_nxt = state;
    pay_ready = 1'b0;
    nxt_v     = 1'b0;
    nxt_d     = 2'b00;
    nxt_ur    = 1'b0;
    crc_clear = 1'b0;
    crc_en    = 1'b0;
    crc_din   = 2'b00;
    case (state)
      IDLE: begin
        if (pay_axiiv) state_nxt = PREAMBLE;
      end
      PREAMBLE: begin
        nxt_v = 1'b1;
        nxt_d = (phase == PRE_LAST) ? 2'b11 : 2'b01;
        if (phase == PRE_LAST) begin
          state_nxt = HEADER;
          crc_clear = 1'b1;
        end
      end
      HEADER: begin
        nxt_v   = 1'b1;
        nxt_d   = hdr_sr[1:0];
        crc_en  = 1'b1;
        crc_din = hdr_sr[1:0];
        if (phase == HDR_LAST) state_nxt = PAYLOAD;
      end
      PAYLOAD: begin
        pay_ready = 1'b1;
        // Starvation and oversize share one abort path, so both together give a single pulse.
        if (!pay_axiiv || (pay_cnt == MAX_DIBITS)) begin
          nxt_ur    = 1'b1;
          state_nxt = IFG;
        end else begin
          nxt_v   = 1'b1;
          nxt_d   = pay_axiid;
          crc_en  = 1'b1;
          crc_din = pay_axiid;
          if (pay_axiil) state_nxt = frame_full ? FCS : PAD;
        end
      end
      PAD: begin
        nxt_v  = 1'b1;
        crc_en = 1'b1;
        if (frame_full) state_nxt = FCS;
      end
      FCS: begin
        nxt_v = 1'b1;
        nxt_d = crc_inv[{phase[3:0], 1'b0} +: 2];
        if (phase == FCS_LAST) state_nxt = IFG;
      end
      IFG: begin
        if (phase == IFG_LAST) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      phase      <= '0;
      pay_cnt    <= '0;
      hdr_sr     <= '0;
      axiov      <= 1'b0;
      axiod      <= 2'b00;
      underrun   <= 1'b0;
      fcs_end    <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state_nxt != state)  phase <= '0;
      else if (phase != '1)    phase <= phase + 6'd1;
      // The dibit count runs on through PAD so padding knows where byte/min-length alignment is.
      if ((state_nxt != state) && (state_nxt != PAD))  pay_cnt <= '0;
      else if ((state == PAYLOAD && nxt_v) || state == PAD) pay_cnt <= pay_cnt_inc;
      if (state == IDLE)        hdr_sr <= wire_order({DEST_MAC, SRC_MAC, ETHERTYPE});
      else if (state == HEADER) hdr_sr <= hdr_sr >> 2;
      axiov      <= nxt_v;
      axiod      <= nxt_d;
      underrun   <= nxt_ur;
      fcs_end    <= (state == FCS) && (phase == FCS_LAST);
      frame_done <= fcs_end;
    end
  end

endmodule
